// File: rtl/rename_reg_file.sv
// rename_reg_file
//   Rename register file with an in-order tag allocator. Dispatch is handed up
//   to two consecutive rename tags per cycle. Execution units write speculative
//   results back into the entries. Dispatch reads operand data and valid bits
//   through two read ports. At commit, the oldest entry's data goes out to the
//   architectural register file and the entry's slot is returned to the pool.
//
//   Optional feature macro: RRF_WB_BYPASS_EN
//     defined   : a writeback is forwarded to the read ports and to the commit
//                 data output in the same cycle it is presented.
//     undefined : read ports show registered state only, so a writeback
//                 becomes visible on the next cycle.
//
//   Ports
//     clk_i, reset_i          clock, synchronous active-high reset
//     req_num_i               tags requested this cycle (0..2)
//     alloc_ok_o              request granted this cycle
//     rrftag1_o, rrftag2_o    first and second allocated tag
//     freenum_o               current number of free entries
//     rsX_rrftag_i            operand read tag (X = 1, 2)
//     rsX_rrf_data_o/valid_o  operand data and written-back flag
//     wb_we_i, wb_rrftag_i,
//     wb_data_i               writeback port
//     com_we_i, com_rrftag_i  commit of the oldest entry
//     com_rrfdata_o           data of the committing entry
module rename_reg_file #(
   parameter int RRF_NUM  = 64,
   parameter int RRF_SEL  = 6,
   parameter int DATA_LEN = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [1:0]          req_num_i,
   output logic                alloc_ok_o,
   output logic [RRF_SEL-1:0]  rrftag1_o,
   output logic [RRF_SEL-1:0]  rrftag2_o,
   output logic [RRF_SEL:0]    freenum_o,
   input  logic [RRF_SEL-1:0]  rs1_rrftag_i,
   output logic [DATA_LEN-1:0] rs1_rrf_data_o,
   output logic                rs1_rrf_valid_o,
   input  logic [RRF_SEL-1:0]  rs2_rrftag_i,
   output logic [DATA_LEN-1:0] rs2_rrf_data_o,
   output logic                rs2_rrf_valid_o,
   input  logic                wb_we_i,
   input  logic [RRF_SEL-1:0]  wb_rrftag_i,
   input  logic [DATA_LEN-1:0] wb_data_i,
   input  logic                com_we_i,
   input  logic [RRF_SEL-1:0]  com_rrftag_i,
   output logic [DATA_LEN-1:0] com_rrfdata_o
);

   localparam logic [RRF_SEL:0] FULL = (RRF_SEL+1)'(RRF_NUM);

   logic [RRF_SEL-1:0]  tail_q, tail_d;
   logic [RRF_SEL:0]    freenum_q, freenum_d;
   logic [RRF_NUM-1:0]  valid_q, valid_d;
   logic [DATA_LEN-1:0] data_q [RRF_NUM];

   logic [RRF_SEL:0]    req_ext;
   logic                grant;
   logic [RRF_SEL:0]    alloc_num;
   logic [RRF_SEL+1:0]  free_sum;
   logic [RRF_SEL-1:0]  tag2;

   assign req_ext   = {{(RRF_SEL-1){1'b0}}, req_num_i};
   // Grant decision uses the count before this cycle's commit is added back,
   // so a same-cycle commit never enables an allocation.
   assign grant     = (req_num_i != 2'd0) && (freenum_q >= req_ext);
   assign alloc_num = grant ? req_ext : '0;
   assign tag2      = tail_q + RRF_SEL'(1);

   assign alloc_ok_o = grant;
   assign rrftag1_o  = tail_q;
   assign rrftag2_o  = tag2;
   assign freenum_o  = freenum_q;

   always_comb begin
      tail_d   = tail_q + alloc_num[RRF_SEL-1:0];
      // One extra bit of headroom so an illegal commit on a full pool can be
      // detected and clamped back to RRF_NUM.
      free_sum = {1'b0, freenum_q} - {1'b0, alloc_num}
               + {{(RRF_SEL+1){1'b0}}, com_we_i};
      freenum_d = (free_sum > {1'b0, FULL}) ? FULL : free_sum[RRF_SEL:0];
   end

   // Allocation clear is applied after the writeback set so it wins on a
   // collision between the two.
   always_comb begin
      valid_d = valid_q;
      if (wb_we_i) begin
         valid_d[wb_rrftag_i] = 1'b1;
      end
      if (grant) begin
         valid_d[tail_q] = 1'b0;
         if (req_num_i[1]) begin
            valid_d[tag2] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tail_q    <= '0;
         freenum_q <= FULL;
         valid_q   <= '0;
      end else begin
         tail_q    <= tail_d;
         freenum_q <= freenum_d;
         valid_q   <= valid_d;
      end
   end

   // Data array carries no reset; entries are meaningful only once valid.
   always_ff @(posedge clk_i) begin
      if (wb_we_i) begin
         data_q[wb_rrftag_i] <= wb_data_i;
      end
   end

   always_comb begin
      rs1_rrf_data_o  = data_q[rs1_rrftag_i];
      rs1_rrf_valid_o = valid_q[rs1_rrftag_i];
      rs2_rrf_data_o  = data_q[rs2_rrftag_i];
      rs2_rrf_valid_o = valid_q[rs2_rrftag_i];
      com_rrfdata_o   = data_q[com_rrftag_i];
`ifdef RRF_WB_BYPASS_EN
      if (wb_we_i && (wb_rrftag_i == rs1_rrftag_i)) begin
         rs1_rrf_data_o  = wb_data_i;
         rs1_rrf_valid_o = 1'b1;
      end
      if (wb_we_i && (wb_rrftag_i == rs2_rrftag_i)) begin
         rs2_rrf_data_o  = wb_data_i;
         rs2_rrf_valid_o = 1'b1;
      end
      if (wb_we_i && (wb_rrftag_i == com_rrftag_i)) begin
         com_rrfdata_o = wb_data_i;
      end
`endif
   end

endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Rename register file (RRF) with in-order tag allocator. It hands out physical rename tags to dispatch, up to two per cycle, and holds speculative results written back by the execution units. It supplies operand data and valid bits to dispatch. At commit it returns the committed entry's data to the architectural register file, which consumes it as its commit write data, and it reclaims the entry.

## Interface
Parameters:
- `RRF_NUM`, default 64: number of rename entries; must be a power of two.
- `RRF_SEL`, default 6: tag width, equal to log2(`RRF_NUM`).
- `DATA_LEN`, default 32: data width.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: synchronous reset, active-high.

Dispatch allocation:
- `req_num_i`, in, 2: number of tags requested this cycle (0, 1 or 2; 3 is illegal).
- `alloc_ok_o`, out, 1: request granted this cycle.
- `rrftag1_o`, out, `RRF_SEL`: first allocated tag.
- `rrftag2_o`, out, `RRF_SEL`: second allocated tag.
- `freenum_o`, out, `RRF_SEL`+1: current number of free entries.

Operand read (two ports, X = 1, 2):
- `rsX_rrftag_i`, in, `RRF_SEL`: tag to read.
- `rsX_rrf_data_o`, out, `DATA_LEN`: data of that entry.
- `rsX_rrf_valid_o`, out, 1: that entry has been written back.

Writeback:
- `wb_we_i`, in, 1: writeback enable.
- `wb_rrftag_i`, in, `RRF_SEL`: destination entry.
- `wb_data_i`, in, `DATA_LEN`: result data.

Commit:
- `com_we_i`, in, 1: one entry commits this cycle.
- `com_rrftag_i`, in, `RRF_SEL`: tag of the committing entry; always the oldest allocated entry.
- `com_rrfdata_o`, out, `DATA_LEN`: data of `com_rrftag_i`, for the architectural file's commit write.

## Operation
State:
- `tail`: allocation pointer, `RRF_SEL` bits.
- `freenum`: free count, `RRF_SEL`+1 bits.
- `valid[RRF_NUM]`: per-entry written-back flags.
- `data[RRF_NUM]`: data array, `DATA_LEN` bits per entry.

Allocation:
- `rrftag1_o` = `tail`; `rrftag2_o` = `tail`+1, taken modulo `RRF_NUM`, so it wraps from 63 to 0.
- `alloc_ok_o` = (`req_num_i` != 0) && (`freenum` >= `req_num_i`), using the pre-update `freenum`.
- On a grant, at the clock edge:
  - `tail` += `req_num_i` (modulo).
  - `valid` of each allocated tag is cleared.
- A request that is not granted has no state effect. Dispatch stalls and retries.
- Tag values are meaningful only when `alloc_ok_o` is 1.

Writeback:
- `data[wb_rrftag_i]` <= `wb_data_i`; `valid[wb_rrftag_i]` <= 1.

Commit:
- `com_rrfdata_o` = `data[com_rrftag_i]`, combinational.
- At the clock edge, `freenum` += 1. Data and valid of the committed entry are left untouched.

Free count:
- The new `freenum` is old `freenum` − (granted ? `req_num_i` : 0) + `com_we_i`, computed in one expression.
- A commit does not free space that an allocation in the same cycle can use.

Reads:
- `rsX_rrf_data_o` and `rsX_rrf_valid_o` are combinational from the arrays.

Boundary conditions:
- `freenum` = 0: every request is denied. A commit in the same cycle brings `freenum` to 1 at the next edge.
- `freenum` = 1 and `req_num_i` = 2: denied; nothing is allocated.
- Writeback to a tag being allocated in the same cycle: the allocation clear of `valid` wins. The system never generates this case.
- `com_we_i` while `freenum` = `RRF_NUM`: illegal. The block holds `freenum` saturated at `RRF_NUM`.
- Reset mid-operation: all state is discarded on the next edge; in-flight requests that cycle are ignored.

## Timing
Reset values:
- `tail` = 0, `freenum` = `RRF_NUM`, all `valid` = 0.
- Resulting outputs: `alloc_ok_o` = 0 with no request, `rrftag1_o` = 0, `rrftag2_o` = 1, `freenum_o` = 64, `rsX_rrf_valid_o` = 0.
- `data` is not reset; data outputs are undefined until the entry is written.

Latencies:
- Allocation: grant and tags are visible in the same cycle; pointer and count update at the next edge.
- Writeback: visible on the read ports from the next cycle. Same-cycle visibility depends on Configuration.
- Commit data: zero latency, combinational.

## Configuration
- `RRF_WB_BYPASS_EN` defined: when `wb_we_i` && `wb_rrftag_i` == `rsX_rrftag_i`, `rsX_rrf_data_o` = `wb_data_i` and `rsX_rrf_valid_o` = 1 in the same cycle. The same bypass applies to `com_rrfdata_o`.
- Not defined: the read ports reflect registered state only, and writeback is visible one cycle later.

## Test plan
1. Reset, then `req_num_i` = 2 -> `alloc_ok_o` = 1, tags 0 and 1; next cycle `freenum_o` = 62 and `rrftag1_o` = 2.
2. Allocate 1 per cycle 63 times, then request 2 -> denied with `freenum_o` = 1; request 1 -> granted with tag 63; next `rrftag1_o` = 0 (wrap); then `freenum_o` = 0 and any request is denied.
3. With `freenum_o` = 0, assert `com_we_i` with `req_num_i` = 1 -> denied this cycle; next cycle `freenum_o` = 1 and the request is granted.
4. Allocate tag 5; writeback tag 5 with data 0xDEADBEEF; read tag 5 -> the same cycle shows valid = 1 and 0xDEADBEEF with the bypass, the next cycle without it.
5. Commit tag 5 -> `com_rrfdata_o` = 0xDEADBEEF and `freenum_o` increments by 1. A simultaneous grant of 2 gives a net change of −1.
6. Assert `reset_i` mid-stream with requests and writebacks pending -> next cycle `freenum_o` = 64, `rrftag1_o` = 0, all valid = 0.
